cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter s_word, default 256, line width in bits.
REQ-002 SHALL have parameter s_beat, default 64, burst beat width in bits; s_word/s_beat beats per line (default 4).
REQ-003 SHALL have parameter s_timeout, default 255, watchdog limit in cycles (used only under REQ-028).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 line_address  input  32  cache-side line address.
REQ-007 line_read  input  1  cache-side line fill request.
REQ-008 line_write  input  1  cache-side line writeback request.
REQ-009 line_wdata  input  s_word  writeback line.
REQ-010 line_rdata  output  s_word  assembled fill line.
REQ-011 line_resp  output  1  one-cycle completion pulse.
REQ-012 burst_address  output  32  line-aligned burst address.
REQ-013 burst_read / burst_write  output  1 each  burst request strobes.
REQ-014 burst_wdata  output  s_beat  current write beat.
REQ-015 burst_rdata  input  s_beat  current read beat.
REQ-016 burst_resp  input  1  memory accepts/returns one beat this cycle.
REQ-017 timeout_err  output  1  sticky watchdog flag.

Function
REQ-018 FSM states SHALL be IDLE, RD_BURST, WR_BURST, DONE; requests sampled only in IDLE.
REQ-019 IDLE: line_write high -> latch line_wdata and {line_address[31:5],5'b0}, go WR_BURST; else line_read high -> latch address, go RD_BURST; both high -> write wins.
REQ-020 RD_BURST/WR_BURST SHALL hold burst_read/burst_write high and burst_address constant until the final beat's burst_resp cycle, inclusive.
REQ-021 Beat counter SHALL count 0..s_word/s_beat-1, advance only on burst_resp, and wrap to 0 on final beat.
REQ-022 Read beat k SHALL be stored into line_rdata[k*s_beat +: s_beat] on its burst_resp cycle; beat 0 is lowest bits.
REQ-023 burst_wdata SHALL equal latched line bits [k*s_beat +: s_beat] for current count k, combinationally from the latch.
REQ-024 Final-beat burst_resp SHALL move to DONE; DONE asserts line_resp for exactly one cycle, then returns to IDLE unconditionally.
REQ-025 Minimum latency: line request in IDLE at cycle 0, burst strobe from cycle 1, line_resp at cycle 1+B+1 when burst_resp is continuous (B=beats); gaps in burst_resp extend latency one cycle each.
REQ-026 line_rdata SHALL remain stable from DONE until the next read burst's first beat; a write burst SHALL NOT alter it.
REQ-027 line_address/line_wdata changes during a burst SHALL be ignored.

Configuration
REQ-028 Macro CACHELINE_ADAPTOR_TIMEOUT_EN defined: counter of consecutive burst cycles without burst_resp; reaching s_timeout sets timeout_err (sticky until reset), FSM aborts to DONE and pulses line_resp. Undefined: timeout_err tied 0, no counter, bursts wait indefinitely.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, beat counter 0, line_rdata 0, latched wdata/address 0, timeout_err 0; all outputs 0 while held.
REQ-030 rst asserted mid-burst SHALL abandon the burst with no line_resp; after release, the block SHALL accept a new request in IDLE.

Structure
REQ-031 State enum adaptor_state_t and beats-per-line constant SHALL reside in package cache_types.
REQ-032 No sub-module; single flat module.

Verification
REQ-033 Read, burst_resp continuous, beats 0x11..,0x22..,0x33..,0x44.. -> line_rdata = {0x44..,0x33..,0x22..,0x11..}, line_resp 6 cycles after request.
REQ-034 Write line 0xDEAD..BEEF at addr 0x0000_1234 -> burst_address 0x0000_1220, 4 beats low-to-high, one line_resp.
REQ-035 Read with burst_resp low 3 cycles between beats 1 and 2 -> counter holds, line_resp 3 cycles later, data correct.
REQ-036 line_read and line_write both high in IDLE -> write burst only.
REQ-037 rst low after beat 2 of a read -> outputs 0 immediately, no line_resp; next read completes correctly.
REQ-038 With CACHELINE_ADAPTOR_TIMEOUT_EN, s_timeout=8, burst_resp never asserted -> timeout_err rises after 8 cycles, one line_resp, stays high until reset.

Source files
------------

// File: rtl/cache_types.sv
// Shared types for the cacheline adaptor: FSM state encoding and beats-per-line helpers.
package cache_types;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adaptor_state_t;

    localparam int BEATS_PER_LINE = 4;

    function automatic int beats_per_line(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges whole-line cache requests onto a beat-serial burst memory port.
// Optional watchdog abort is enabled with `define CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor
    import cache_types::*;
#(
    parameter int s_word    = 256,
    parameter int s_beat    = 64,
    parameter int s_timeout = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       line_address,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [s_word-1:0] line_wdata,
    output logic [s_word-1:0] line_rdata,
    output logic              line_resp,
    output logic [31:0]       burst_address,
    output logic              burst_read,
    output logic              burst_write,
    output logic [s_beat-1:0] burst_wdata,
    input  logic [s_beat-1:0] burst_rdata,
    input  logic              burst_resp,
    output logic              timeout_err
);

    localparam int beats = beats_per_line(s_word, s_beat);
    localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;

    if ((s_word % s_beat) != 0 || s_timeout < 1) begin : g_bad_cfg
        $error("cacheline_adaptor: bad parameter combination");
    end

    adaptor_state_t    state, state_next;
    logic [cnt_w-1:0]  count;
    logic [s_word-1:0] wdata_q;
    logic [31:0]       addr_q;
    logic              last_beat;
    logic              timeout_hit;
    logic              in_burst;

    assign in_burst  = (state == RD_BURST) || (state == WR_BURST);
    assign last_beat = burst_resp && (count == cnt_w'(beats - 1));

    assign burst_address = addr_q;
    assign burst_wdata   = wdata_q[int'(count)*s_beat +: s_beat];

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int tw = (s_timeout > 1) ? $clog2(s_timeout + 1) : 1;
    logic [tw-1:0] stall_cnt;
    logic          err_q;

    // Counts consecutive burst cycles with no beat accepted.
    assign timeout_hit = in_burst && !burst_resp && (stall_cnt == tw'(s_timeout - 1));
    assign timeout_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (!in_burst || burst_resp) stall_cnt <= '0;
            else                         stall_cnt <= stall_cnt + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            line_rdata <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (line_write) begin
                        wdata_q <= line_wdata;
                        addr_q  <= line_address & ~32'h1f;
                    end else if (line_read) begin
                        addr_q  <= line_address & ~32'h1f;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (timeout_hit) begin
                        count <= '0;
                    end else if (burst_resp) begin
                        count <= last_beat ? '0 : count + 1'b1;
                        if (state == RD_BURST)
                            line_rdata[int'(count)*s_beat +: s_beat] <= burst_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        burst_read  = (state == RD_BURST);
        burst_write = (state == WR_BURST);
        line_resp   = (state == DONE);
        case (state)
            IDLE: begin
                if (line_write)     state_next = WR_BURST;
                else if (line_read) state_next = RD_BURST;
            end
            RD_BURST, WR_BURST: begin
                if (last_beat || timeout_hit) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor; the memory side answers one cycle after the strobe.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  line_address = '0;
    logic         line_read = 1'b0;
    logic         line_write = 1'b0;
    logic [255:0] line_wdata = '0;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata = '0;
    logic         burst_resp = 1'b0;
    logic         timeout_err;

    int checks = 0;
    int failures = 0;

    // Observations recorded by the memory model.
    int          lat, resp_cnt, rd_cyc, wr_cyc;
    bit          addr_ok;
    logic [63:0] rbeats [4];
    logic [63:0] wbeats [4];

    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'hD4D4_D4D4_D4D4_D4D4, 64'hC3C3_C3C3_C3C3_C3C3,
                                       64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1A1};
    localparam logic [255:0] WLINE  = 256'hDEAD_0000_0000_0003_CAFE_0000_0000_0002_F00D_0000_0000_0001_0000_0000_0000_BEEF;

    cacheline_adaptor #(.s_word(256), .s_beat(64), .s_timeout(8)) dut (
        .clk(clk), .rst(rst),
        .line_address(line_address), .line_read(line_read), .line_write(line_write),
        .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
        .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
        .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Call at cycle 0 with the request already driven; runs max_cyc cycles.
    // Stalls gap_len cycles before accepting beat gap_at. Garbles line inputs after cycle 0.
    task automatic mem_run(input logic [31:0] exp_addr, input int gap_at, input int gap_len,
                           input int max_cyc);
        int beat = 0, strobe = 0, waited = 0;
        lat = -1; resp_cnt = 0; rd_cyc = 0; wr_cyc = 0; addr_ok = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                line_read = 1'b0; line_write = 1'b0;
                line_address = 32'hFFFF_FFC0; line_wdata = ~line_wdata;
            end
            burst_resp = 1'b0;
            if (line_resp) begin
                resp_cnt++;
                if (lat < 0) lat = c;
            end
            if (burst_read)  rd_cyc++;
            if (burst_write) wr_cyc++;
            if (burst_read || burst_write) begin
                strobe++;
                if (burst_address !== exp_addr) addr_ok = 1'b0;
                if (strobe >= 2 && beat < 4) begin
                    if (beat == gap_at && waited < gap_len) waited++;
                    else begin
                        if (burst_write) wbeats[beat] = burst_wdata;
                        burst_rdata = rbeats[beat];
                        burst_resp = 1'b1;
                        beat++;
                    end
                end
            end
        end
        burst_resp = 1'b0;
    endtask

    task automatic set_rbeats(input logic [255:0] l);
        for (int k = 0; k < 4; k++) rbeats[k] = l[k*64 +: 64];
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata, timeout_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdata=%h resp=%b addr=%h rd=%b wr=%b wdata=%h err=%b, want all 0",
                     line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata, timeout_err);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_basic();
        set_rbeats(LINE_A);
        line_address = 32'h0000_2468; line_read = 1'b1;
        mem_run(32'h0000_2460, 9, 0, 12);
        checks++; if (line_rdata !== LINE_A) begin failures++; $display("FAIL read_data: got %h want %h", line_rdata, LINE_A); end
        checks++; if (lat !== 6) begin failures++; $display("FAIL read_latency: got %0d want 6", lat); end
        checks++; if (resp_cnt !== 1) begin failures++; $display("FAIL read_resp_count: got %0d want 1", resp_cnt); end
        checks++; if (rd_cyc !== 5 || wr_cyc !== 0) begin failures++; $display("FAIL read_strobes: got rd=%0d wr=%0d want rd=5 wr=0", rd_cyc, wr_cyc); end
        checks++; if (!addr_ok) begin failures++; $display("FAIL read_address: got unstable/wrong want 00002460"); end
    endtask

    task automatic test_write();
        line_address = 32'h0000_1234; line_wdata = WLINE; line_write = 1'b1;
        mem_run(32'h0000_1220, 9, 0, 12);
        checks++; if (wbeats[0] !== 64'h0000_0000_0000_BEEF) begin failures++; $display("FAIL write_beat0: got %h want 000000000000beef", wbeats[0]); end
        checks++; if (wbeats[1] !== 64'hF00D_0000_0000_0001) begin failures++; $display("FAIL write_beat1: got %h want f00d000000000001", wbeats[1]); end
        checks++; if (wbeats[2] !== 64'hCAFE_0000_0000_0002) begin failures++; $display("FAIL write_beat2: got %h want cafe000000000002", wbeats[2]); end
        checks++; if (wbeats[3] !== 64'hDEAD_0000_0000_0003) begin failures++; $display("FAIL write_beat3: got %h want dead000000000003", wbeats[3]); end
        checks++; if (!addr_ok) begin failures++; $display("FAIL write_address: got unstable/wrong want 00001220"); end
        checks++; if (lat !== 6 || resp_cnt !== 1) begin failures++; $display("FAIL write_resp: got lat=%0d cnt=%0d want lat=6 cnt=1", lat, resp_cnt); end
        checks++; if (wr_cyc !== 5 || rd_cyc !== 0) begin failures++; $display("FAIL write_strobes: got wr=%0d rd=%0d want wr=5 rd=0", wr_cyc, rd_cyc); end
        checks++; if (line_rdata !== LINE_A) begin failures++; $display("FAIL write_keeps_rdata: got %h want %h", line_rdata, LINE_A); end
    endtask

    task automatic test_read_gap();
        set_rbeats(LINE_B);
        line_address = 32'h8000_00FF; line_read = 1'b1;
        mem_run(32'h8000_00E0, 2, 3, 14);
        checks++; if (line_rdata !== LINE_B) begin failures++; $display("FAIL gap_data: got %h want %h", line_rdata, LINE_B); end
        checks++; if (lat !== 9 || resp_cnt !== 1) begin failures++; $display("FAIL gap_resp: got lat=%0d cnt=%0d want lat=9 cnt=1", lat, resp_cnt); end
        checks++; if (rd_cyc !== 8) begin failures++; $display("FAIL gap_strobes: got %0d want 8", rd_cyc); end
    endtask

    task automatic test_both_requests();
        line_address = 32'h0000_0040; line_wdata = WLINE; line_read = 1'b1; line_write = 1'b1;
        mem_run(32'h0000_0040, 9, 0, 12);
        checks++; if (wr_cyc !== 5 || rd_cyc !== 0) begin failures++; $display("FAIL both_write_wins: got wr=%0d rd=%0d want wr=5 rd=0", wr_cyc, rd_cyc); end
        checks++; if (wbeats[3] !== 64'hDEAD_0000_0000_0003 || resp_cnt !== 1) begin failures++; $display("FAIL both_data: got beat3=%h cnt=%0d want dead000000000003 cnt=1", wbeats[3], resp_cnt); end
        checks++; if (line_rdata !== LINE_B) begin failures++; $display("FAIL both_keeps_rdata: got %h want %h", line_rdata, LINE_B); end
    endtask

    task automatic test_reset_mid_burst();
        int seen = 0;
        set_rbeats(LINE_A);
        line_address = 32'h0000_3000; line_read = 1'b1;
        @(posedge clk); #1; line_read = 1'b0;                // cycle 1: strobe, no beat yet
        for (int k = 0; k < 3; k++) begin
            burst_rdata = rbeats[k]; burst_resp = 1'b1;
            @(posedge clk); #1;
        end
        burst_resp = 1'b0;
        rst = 1'b0; #1;
        checks++;
        if ({line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata, timeout_err} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got rdata=%h resp=%b addr=%h rd=%b wr=%b err=%b, want all 0",
                     line_rdata, line_resp, burst_address, burst_read, burst_write, timeout_err);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (line_resp) seen++;
        end
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (line_resp || burst_read) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL reset_mid_no_resp: got %0d resp/strobe cycles want 0", seen); end
        set_rbeats(LINE_B);
        line_address = 32'h0000_3010; line_read = 1'b1;
        mem_run(32'h0000_3000, 9, 0, 12);
        checks++; if (line_rdata !== LINE_B || lat !== 6 || resp_cnt !== 1) begin
            failures++; $display("FAIL reset_mid_recover: got data=%h lat=%0d cnt=%0d want %h lat=6 cnt=1", line_rdata, lat, resp_cnt, LINE_B);
        end
    endtask

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    task automatic test_timeout();
        int resps = 0;
        bit early = 1'b0;
        line_address = 32'h0000_5000; line_read = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            line_read = 1'b0;
            if (line_resp) resps++;
            if (c <= 8 && timeout_err) early = 1'b1;
            if (c == 9) begin
                checks++; if (timeout_err !== 1'b1 || line_resp !== 1'b1) begin failures++; $display("FAIL timeout_rise: got err=%b resp=%b want err=1 resp=1", timeout_err, line_resp); end
            end
        end
        checks++; if (early) begin failures++; $display("FAIL timeout_early: got err before cycle 9 want none"); end
        checks++; if (resps !== 1) begin failures++; $display("FAIL timeout_resp_count: got %0d want 1", resps); end
        checks++; if (timeout_err !== 1'b1 || burst_read !== 1'b0) begin failures++; $display("FAIL timeout_sticky: got err=%b rd=%b want err=1 rd=0", timeout_err, burst_read); end
        rst = 1'b0; #1;
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask
`else
    task automatic test_no_timeout();
        set_rbeats(LINE_A);
        line_address = 32'h0000_6000; line_read = 1'b1;
        mem_run(32'h0000_6000, 0, 20, 30);
        checks++; if (lat !== 26 || resp_cnt !== 1) begin failures++; $display("FAIL long_stall_resp: got lat=%0d cnt=%0d want lat=26 cnt=1", lat, resp_cnt); end
        checks++; if (timeout_err !== 1'b0 || line_rdata !== LINE_A) begin failures++; $display("FAIL long_stall_data: got err=%b data=%h want err=0 data=%h", timeout_err, line_rdata, LINE_A); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_basic();
        test_write();
        test_read_gap();
        test_both_requests();
        test_reset_mid_burst();
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
